// File: rtl/psum_mem_pkg.sv
// Shared definitions for the partial-sum buffer controller: FSM state
// encoding, buffer depth helper and the out-of-range address check.
package psum_mem_pkg;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Number of words held by a buffer with 2**log2 entries.
    function automatic int unsigned depth_of(input int unsigned log2);
        return 32'd1 << log2;
    endfunction

    // True when any address bit at or above depth_log2 is set.
    function automatic logic addr_oor(input logic [63:0] addr, input int unsigned depth_log2);
        return (addr >> depth_log2) != '0;
    endfunction

endpackage

// File: rtl/psum_mem_bram.sv
// Simple dual-port buffer RAM: one write port, one read port with a
// registered (1-cycle) read. A same-address read and write in one cycle
// returns the old word; the controller handles write-first forwarding.
module psum_mem_bram
    import psum_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = depth_of(DEPTH_LOG2);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port and registered read port share one clocked process.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/psum_mem_ctrl.sv
// Partial-sum buffer controller on the memctrl0 responder interface.
// Zero-fills the buffer after reset or on i_clear, accepts accumulator
// write-backs, and serves reads with a fixed latency of MEM_DELAY (1 or 2)
// cycles. The accelerator owns the read port; host reads use idle slots.
// Optional debug counters are built when PSUM_MEM_STATS_EN is defined.
module psum_mem_ctrl
    import psum_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 12,
    parameter int MEM_DELAY  = 1,
    parameter int REG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] memctrl0_wadd,
    input  logic                  memctrl0_wren,
    input  logic [DATA_WIDTH-1:0] memctrl0_idat,
    input  logic [ADDR_WIDTH-1:0] memctrl0_radd,
    input  logic                  memctrl0_rden,
    output logic [DATA_WIDTH-1:0] memctrl0_odat,
    output logic                  memctrl0_ovld,
    input  logic [ADDR_WIDTH-1:0] host_radd,
    input  logic                  host_rden,
    output logic                  host_rack,
    output logic [DATA_WIDTH-1:0] host_odat,
    output logic                  host_ovld,
    input  logic                  i_clear,
    output logic                  o_ready,
    output logic                  o_err
`ifdef PSUM_MEM_STATS_EN
    ,
    output logic [REG_WIDTH-1:0]  dbg_wr_cnt,
    output logic [REG_WIDTH-1:0]  dbg_rd_cnt,
    output logic [REG_WIDTH-1:0]  dbg_conflict_cnt
`endif
);

    logic [0:0]            state;
    logic [DEPTH_LOG2-1:0] clr_cnt;
    logic                  ready;
    logic                  in_clear;

    logic                  wr_oor, rd_oor, hst_oor;
    logic                  wr_acc, rd_acc, rd_sel_oor, byp_hit;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  err_evt;

    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_q;

    logic                  vld_p1, own_p1, oor_p1, byp_p1;
    logic [DATA_WIDTH-1:0] bypdat_p1, rdat_p1;
    logic                  acc_vld_p1, host_vld_p1;

    // Requests are honoured only in READY and never while rst is high.
    assign ready    = (state == ST_READY) & ~rst;
    assign in_clear = (state == ST_CLEAR) & ~rst;
    assign o_ready  = (state == ST_READY);

    assign wr_oor  = addr_oor(64'(memctrl0_wadd), DEPTH_LOG2);
    assign rd_oor  = addr_oor(64'(memctrl0_radd), DEPTH_LOG2);
    assign hst_oor = addr_oor(64'(host_radd), DEPTH_LOG2);

    // Accelerator always wins the single read port.
    assign host_rack  = host_rden & ~memctrl0_rden & ready;
    assign wr_acc     = ready & memctrl0_wren & ~wr_oor;
    assign rd_acc     = ready & (memctrl0_rden | host_rden);
    assign rd_idx     = memctrl0_rden ? memctrl0_radd[DEPTH_LOG2-1:0] : host_radd[DEPTH_LOG2-1:0];
    assign rd_sel_oor = memctrl0_rden ? rd_oor : hst_oor;
    // Both addresses are in range here, so matching low bits means same word.
    assign byp_hit    = wr_acc & rd_acc & ~rd_sel_oor & (memctrl0_wadd[DEPTH_LOG2-1:0] == rd_idx);

    // Zero-fill owns the write port while clearing.
    assign ram_we    = in_clear | wr_acc;
    assign ram_waddr = in_clear ? clr_cnt : memctrl0_wadd[DEPTH_LOG2-1:0];
    assign ram_wdata = in_clear ? '0 : memctrl0_idat;

    psum_mem_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_acc),
        .raddr (rd_idx),
        .rdata (ram_q)
    );

    // Clear/ready FSM; the clear counter walks every address once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            if (&clr_cnt) state <= ST_READY;
            clr_cnt <= clr_cnt + 1'b1;
        end else if (i_clear) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end
    end

    // Dropped requests during clear and out-of-range accesses raise a sticky error.
    assign err_evt = (in_clear & (memctrl0_wren | memctrl0_rden | host_rden))
                   | (ready & ((memctrl0_wren & wr_oor) | (memctrl0_rden & rd_oor)
                             | (host_rack & hst_oor)));

    // Sticky error flag, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst)          o_err <= 1'b0;
        else if (err_evt) o_err <= 1'b1;
    end

    // ---- stage p0 -> p1: read valid and owner tag (host = 1)
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            own_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_acc;
            own_p1 <= ~memctrl0_rden;
        end
    end

    // Stage p1 data side: range flag and write-first forwarding word.
    always_ff @(posedge clk) begin
        oor_p1    <= rd_sel_oor;
        byp_p1    <= byp_hit;
        bypdat_p1 <= memctrl0_idat;
    end

    assign rdat_p1     = oor_p1 ? '0 : (byp_p1 ? bypdat_p1 : ram_q);
    assign acc_vld_p1  = vld_p1 & ~own_p1;
    assign host_vld_p1 = vld_p1 & own_p1;

    generate
        if (MEM_DELAY == 2) begin : g_out_reg
            logic                  acc_vld_p2, host_vld_p2;
            logic [DATA_WIDTH-1:0] dat_p2;

            // ---- stage p1 -> p2: output valid register
            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_vld_p2  <= 1'b0;
                    host_vld_p2 <= 1'b0;
                end else begin
                    acc_vld_p2  <= acc_vld_p1;
                    host_vld_p2 <= host_vld_p1;
                end
            end

            // Stage p2 data register, shared by both requesters.
            always_ff @(posedge clk) begin
                dat_p2 <= rdat_p1;
            end

            assign memctrl0_ovld = acc_vld_p2;
            assign memctrl0_odat = acc_vld_p2 ? dat_p2 : '0;
            assign host_ovld     = host_vld_p2;
            assign host_odat     = host_vld_p2 ? dat_p2 : '0;
        end else begin : g_out_comb
            assign memctrl0_ovld = acc_vld_p1;
            assign memctrl0_odat = acc_vld_p1 ? rdat_p1 : '0;
            assign host_ovld     = host_vld_p1;
            assign host_odat     = host_vld_p1 ? rdat_p1 : '0;
        end
    endgenerate

`ifdef PSUM_MEM_STATS_EN
    // Debug event counters, restarted together with the buffer.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            dbg_wr_cnt       <= '0;
            dbg_rd_cnt       <= '0;
            dbg_conflict_cnt <= '0;
        end else begin
            if (wr_acc) dbg_wr_cnt <= dbg_wr_cnt + 1'b1;
            if (rd_acc) dbg_rd_cnt <= dbg_rd_cnt + 1'b1;
            if (host_rden & memctrl0_rden) dbg_conflict_cnt <= dbg_conflict_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_psum_mem_ctrl.sv
// Directed bench for psum_mem_ctrl with a 16-word buffer. Two instances
// share all inputs: one with MEM_DELAY=1, one with MEM_DELAY=2.
module tb_psum_mem_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [AW-1:0] memctrl0_wadd;
    logic          memctrl0_wren;
    logic [DW-1:0] memctrl0_idat;
    logic [AW-1:0] memctrl0_radd;
    logic          memctrl0_rden;
    logic [AW-1:0] host_radd;
    logic          host_rden;
    logic          i_clear;

    logic [DW-1:0] memctrl0_odat, host_odat;
    logic          memctrl0_ovld, host_rack, host_ovld, o_ready, o_err;
    logic [DW-1:0] d2_odat, d2_host_odat;
    logic          d2_ovld, d2_host_rack, d2_host_ovld, d2_o_ready, d2_o_err;
`ifdef PSUM_MEM_STATS_EN
    logic [31:0]   wr_cnt, rd_cnt, cf_cnt, d2_wr_cnt, d2_rd_cnt, d2_cf_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int n;

    psum_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(4), .MEM_DELAY(1), .REG_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .memctrl0_wadd(memctrl0_wadd), .memctrl0_wren(memctrl0_wren), .memctrl0_idat(memctrl0_idat),
        .memctrl0_radd(memctrl0_radd), .memctrl0_rden(memctrl0_rden),
        .memctrl0_odat(memctrl0_odat), .memctrl0_ovld(memctrl0_ovld),
        .host_radd(host_radd), .host_rden(host_rden), .host_rack(host_rack),
        .host_odat(host_odat), .host_ovld(host_ovld),
        .i_clear(i_clear), .o_ready(o_ready), .o_err(o_err)
`ifdef PSUM_MEM_STATS_EN
        , .dbg_wr_cnt(wr_cnt), .dbg_rd_cnt(rd_cnt), .dbg_conflict_cnt(cf_cnt)
`endif
    );

    psum_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(4), .MEM_DELAY(2), .REG_WIDTH(32)) dut2 (
        .clk(clk), .rst(rst),
        .memctrl0_wadd(memctrl0_wadd), .memctrl0_wren(memctrl0_wren), .memctrl0_idat(memctrl0_idat),
        .memctrl0_radd(memctrl0_radd), .memctrl0_rden(memctrl0_rden),
        .memctrl0_odat(d2_odat), .memctrl0_ovld(d2_ovld),
        .host_radd(host_radd), .host_rden(host_rden), .host_rack(d2_host_rack),
        .host_odat(d2_host_odat), .host_ovld(d2_host_ovld),
        .i_clear(i_clear), .o_ready(d2_o_ready), .o_err(d2_o_err)
`ifdef PSUM_MEM_STATS_EN
        , .dbg_wr_cnt(d2_wr_cnt), .dbg_rd_cnt(d2_rd_cnt), .dbg_conflict_cnt(d2_cf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        memctrl0_wren = 1'b0;
        memctrl0_rden = 1'b0;
        host_rden     = 1'b0;
        i_clear       = 1'b0;
        for (int k = 0; k < cycles; k++) tick();
    endtask

    // Counts cycles with o_ready low from the current cycle, bounded.
    task automatic count_clear(output int cyc);
        cyc = 0;
        while (o_ready !== 1'b1 && cyc < 40) begin
            cyc++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        memctrl0_wadd = '0; memctrl0_wren = 1'b0; memctrl0_idat = '0;
        memctrl0_radd = '0; memctrl0_rden = 1'b0;
        host_radd = '0; host_rden = 1'b0; i_clear = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_ready", o_ready, 0);
        chk("rst_err", o_err, 0);
        chk("rst_ovld", memctrl0_ovld, 0);
        chk("rst_odat", memctrl0_odat, 0);
        chk("rst_hovld", host_ovld, 0);

        // 1. initial zero-fill takes 16 cycles, then every word reads 0
        rst = 1'b0;
        count_clear(n);
        chk("t1_clr_len", n, 16);
        chk("t1_d2_ready", d2_o_ready, 1);
        for (int i = 0; i <= 16; i++) begin
            memctrl0_rden = (i < 16);
            memctrl0_radd = 32'(i);
            #1;
            if (i > 0) chk("t1_rd", {memctrl0_ovld, memctrl0_odat}, {1'b1, 32'h0});
            if (i > 1) chk("t1_rd_d2", {d2_ovld, d2_odat}, {1'b1, 32'h0});
            tick();
        end
        idle(3);

        // 2. write then read-back, latency 1 and 2
        memctrl0_wren = 1'b1; memctrl0_wadd = 32'd3; memctrl0_idat = 32'h12345678;
        tick();
        memctrl0_wren = 1'b0;
        memctrl0_rden = 1'b1; memctrl0_radd = 32'd3;
        #1;
        chk("t2_no_early", memctrl0_ovld, 0);
        tick();
        memctrl0_rden = 1'b0;
        #1;
        chk("t2_d1", {memctrl0_ovld, memctrl0_odat}, {1'b1, 32'h12345678});
        chk("t2_d2_early", d2_ovld, 0);
        tick();
        chk("t2_d1_once", {memctrl0_ovld, memctrl0_odat}, {1'b0, 32'h0});
        chk("t2_d2", {d2_ovld, d2_odat}, {1'b1, 32'h12345678});
        tick();
        chk("t2_d2_once", d2_ovld, 0);
        idle(2);

        // 3. same-cycle write and read of one word return the new data
        memctrl0_wren = 1'b1; memctrl0_wadd = 32'd5; memctrl0_idat = 32'hA5;
        memctrl0_rden = 1'b1; memctrl0_radd = 32'd5;
        tick();
        memctrl0_wren = 1'b0;
        #1;
        chk("t3_bypass", {memctrl0_ovld, memctrl0_odat}, {1'b1, 32'hA5});
        tick();
        memctrl0_rden = 1'b0;
        #1;
        chk("t3_stored", {memctrl0_ovld, memctrl0_odat}, {1'b1, 32'hA5});
        idle(3);

        // 4. held host read waits for an idle accelerator slot
        for (int k = 1; k <= 4; k++) begin
            host_rden = 1'b1; host_radd = 32'd3;
            memctrl0_rden = (k <= 3); memctrl0_radd = 32'd5;
            #1;
            chk("t4_rack", host_rack, (k == 4));
            if (k == 4) chk("t4_rack_d2", d2_host_rack, 1);
            if (k >= 2) chk("t4_acc", {memctrl0_ovld, memctrl0_odat}, {1'b1, 32'hA5});
            chk("t4_hovld_idle", host_ovld, 0);
            tick();
        end
        host_rden = 1'b0; memctrl0_rden = 1'b0;
        #1;
        chk("t4_host", {host_ovld, host_odat}, {1'b1, 32'h12345678});
        chk("t4_acc_end", memctrl0_ovld, 0);
        tick();
        chk("t4_host_once", host_ovld, 0);
        chk("t4_host_d2", {d2_host_ovld, d2_host_odat}, {1'b1, 32'h12345678});
        idle(2);

        // 5. out-of-range write dropped, out-of-range read returns 0
        chk("t5_err_before", o_err, 0);
        memctrl0_wren = 1'b1; memctrl0_wadd = 32'h10; memctrl0_idat = 32'hDEAD;
        memctrl0_rden = 1'b1; memctrl0_radd = 32'h20;
        tick();
        memctrl0_wren = 1'b0;
        memctrl0_radd = 32'd0;
        #1;
        chk("t5_oor_rd", {memctrl0_ovld, memctrl0_odat}, {1'b1, 32'h0});
        chk("t5_err", o_err, 1);
        chk("t5_err_d2", d2_o_err, 1);
        tick();
        memctrl0_rden = 1'b0;
        #1;
        chk("t5_no_write", {memctrl0_ovld, memctrl0_odat}, {1'b1, 32'h0});
        idle(4);
        chk("t5_err_sticky", o_err, 1);

        // 6a. clear with a read in flight; data from before the clear still arrives
        memctrl0_rden = 1'b1; memctrl0_radd = 32'd3;
        tick();
        memctrl0_rden = 1'b0; i_clear = 1'b1;
        #1;
        chk("t6_inflight_d1", {memctrl0_ovld, memctrl0_odat}, {1'b1, 32'h12345678});
        tick();
        i_clear = 1'b0;
        chk("t6_inflight_d2", {d2_ovld, d2_odat}, {1'b1, 32'h12345678});
        count_clear(n);
        chk("t6_clr_len", n, 16);
        memctrl0_rden = 1'b1; memctrl0_radd = 32'd3;
        tick();
        memctrl0_radd = 32'd5;
        #1;
        chk("t6_zero3", {memctrl0_ovld, memctrl0_odat}, {1'b1, 32'h0});
        tick();
        memctrl0_rden = 1'b0;
        #1;
        chk("t6_zero5", {memctrl0_ovld, memctrl0_odat}, {1'b1, 32'h0});
        idle(3);

        // 6b. rst at clear count 7 restarts a full-length clear
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_rst_err", o_err, 0);
        chk("t6_rst_ready", o_ready, 0);
        n = 0;
        while (o_ready !== 1'b1 && n < 40) begin
            memctrl0_rden = (n == 2); host_rden = (n == 2);
            memctrl0_radd = 32'd3; host_radd = 32'd3;
            #1;
            if (n == 2) chk("t6_clr_rack", host_rack, 0);
            if (n == 3) chk("t6_clr_ovld", {memctrl0_ovld, host_ovld}, 2'b00);
            n++;
            tick();
        end
        memctrl0_rden = 1'b0; host_rden = 1'b0;
        chk("t6_restart_len", n, 16);
        chk("t6_clr_err", o_err, 1);
        idle(2);

        // rst while reads are in flight discards them
        memctrl0_rden = 1'b1; memctrl0_radd = 32'd5;
        tick();
        rst = 1'b1; memctrl0_radd = 32'd3;
        tick();
        rst = 1'b0; memctrl0_rden = 1'b0;
        #1;
        chk("t6_rst_flush_d1", memctrl0_ovld, 0);
        chk("t6_rst_flush_d2", d2_ovld, 0);
        count_clear(n);
        chk("t6_final_len", n, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule
